// File: rtl/add_stream_pkg.sv
// Shared types and arithmetic for the add_stream_unit datapath.
// Optional build macro ADD_STREAM_SAT_EN: when defined, ADD/ACC saturate to all-ones on carry and SUB clamps to zero on borrow.
// add_compute is the single source of truth for the per-beat arithmetic.
package add_stream_pkg;

  // Default datapath width, and the widest datapath the shared result struct can carry.
  localparam int unsigned ADD_W_DEF = 4;
  localparam int unsigned ADD_W_MAX = 32;
  localparam int unsigned IDX_W     = $clog2(ADD_W_MAX + 1);

  typedef enum logic [1:0] {
    ADD  = 2'b00,
    SUB  = 2'b01,
    ACC  = 2'b10,
    LOAD = 2'b11
  } add_mode_e;

  // Result of one beat. Only the low <width> bits of sum are meaningful; the rest are zero.
  typedef struct packed {
    logic [ADD_W_MAX-1:0] sum;
    logic                 carry;
    logic                 ovf;
  } add_res_t;

  // Computes one beat at (width+1) bits. 'width' must be a constant at the call site.
  function automatic add_res_t add_compute(
    input logic [ADD_W_MAX-1:0] op_a_in,
    input logic [ADD_W_MAX-1:0] op_b_in,
    input logic [ADD_W_MAX-1:0] acc_in,
    input add_mode_e            mode,
    input int unsigned          width
  );
    logic [ADD_W_MAX:0] mask;
    logic [ADD_W_MAX:0] op_a;
    logic [ADD_W_MAX:0] op_b;
    logic [ADD_W_MAX:0] op_acc;
    logic [ADD_W_MAX:0] raw;
    logic [ADD_W_MAX:0] res_w;
    logic [IDX_W-1:0]   top_idx;
    logic [IDX_W-1:0]   msb_idx;
    logic               sign_a;
    logic               sign_b;
    logic               sign_acc;
    logic               sign_r;
    logic               cy;
    logic               ov;
    add_res_t           res;

    mask    = ((ADD_W_MAX + 1)'(1) << width) - (ADD_W_MAX + 1)'(1);
    top_idx = IDX_W'(width);
    msb_idx = IDX_W'(width - 1);

    op_a   = {1'b0, op_a_in} & mask;
    op_b   = {1'b0, op_b_in} & mask;
    op_acc = {1'b0, acc_in}  & mask;

    sign_a   = op_a[msb_idx];
    sign_b   = op_b[msb_idx];
    sign_acc = op_acc[msb_idx];

    // The bit just above the result MSB is the carry for adds and the borrow for subtract.
    case (mode)
      ADD:     raw = op_a + op_b;
      SUB:     raw = op_a - op_b;
      ACC:     raw = op_acc + op_a;
      default: raw = op_a;
    endcase

    sign_r = raw[msb_idx];
    cy     = 1'b0;
    ov     = 1'b0;
    case (mode)
      ADD: begin
        cy = raw[top_idx];
        ov = (sign_a == sign_b) && (sign_r != sign_a);
      end
      SUB: begin
        cy = raw[top_idx];
        ov = (sign_a != sign_b) && (sign_r != sign_a);
      end
      ACC: begin
        cy = raw[top_idx];
        ov = (sign_acc == sign_a) && (sign_r != sign_a);
      end
      default: begin
        cy = 1'b0;
        ov = 1'b0;
      end
    endcase

    res_w = raw & mask;
`ifdef ADD_STREAM_SAT_EN
    // Clamp on the raw carry/borrow; flags still report the unclamped condition.
    if (cy) begin
      if (mode == SUB) begin
        res_w = '0;
      end else if (mode != LOAD) begin
        res_w = mask;
      end
    end
`endif

    res.sum   = res_w[ADD_W_MAX-1:0];
    res.carry = cy;
    res.ovf   = ov;
    return res;
  endfunction

endpackage

// File: rtl/add_stream_unit_fifo.sv
// Generic synchronous FIFO for add_stream results (module add_res_fifo).
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: push is ignored while full and pop while empty; no same-cycle pass-through.
module add_res_fifo
  import add_stream_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = add_res_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  T                           push_dat,
  input  logic                       pop,
  output T                           pop_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign pop_dat = mem_q[rd_ptr_q];

  // Next pointer/occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read while the occupancy says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat;
    end
  end

endmodule

// File: rtl/add_stream_unit.sv
// Streaming add/sub/accumulate/load unit with a result FIFO (macro ADD_STREAM_SAT_EN selects saturating arithmetic).
// Latency: one cycle from accepted beat to out_valid when the FIFO was empty.
// Backpressure: in_ready drops while the FIFO is full or in reset; a pop at full frees a slot only for the next cycle.
module add_stream_unit
  import add_stream_pkg::*;
#(
  parameter int ADD_WIDTH  = ADD_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ADD_WIDTH-1:0]          a,
  input  logic [ADD_WIDTH-1:0]          b,
  input  logic [1:0]                    mode,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ADD_WIDTH-1:0]          sum,
  output logic                          carry,
  output logic                          ovf,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // FIFO entry narrowed to this instance's width.
  typedef struct packed {
    logic [ADD_WIDTH-1:0] sum;
    logic                 carry;
    logic                 ovf;
  } beat_res_t;

  add_mode_e            mode_e;
  add_res_t             res_full;
  beat_res_t            push_dat;
  beat_res_t            head_dat;
  logic                 full;
  logic                 empty;
  logic                 accept;
  logic                 pop;
  logic [CNT_W-1:0]     fifo_count;
  logic [ADD_WIDTH-1:0] acc_q, acc_d;
  logic                 unused_res_hi;

  assign in_ready  = !full && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign count     = fifo_count;

  // Per-beat arithmetic, evaluated from the presented operands and the current accumulator.
  always_comb begin
    mode_e         = add_mode_e'(mode);
    res_full       = add_compute(ADD_W_MAX'(a), ADD_W_MAX'(b), ADD_W_MAX'(acc_q), mode_e, ADD_WIDTH);
    push_dat.sum   = res_full.sum[ADD_WIDTH-1:0];
    push_dat.carry = res_full.carry;
    push_dat.ovf   = res_full.ovf;
    unused_res_hi  = ^(res_full.sum >> ADD_WIDTH);
  end

  // Accumulator follows the written result on accepted ACC/LOAD beats only.
  always_comb begin
    acc_d = acc_q;
    if (accept && ((mode_e == ACC) || (mode_e == LOAD))) begin
      acc_d = push_dat.sum;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  add_res_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (beat_res_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (accept),
    .push_dat (push_dat),
    .pop      (pop),
    .pop_dat  (head_dat),
    .full     (full),
    .empty    (empty),
    .count    (fifo_count)
  );

  // Outputs read as zero while there is nothing at the head.
  always_comb begin
    sum   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    if (!empty) begin
      sum   = head_dat.sum;
      carry = head_dat.carry;
      ovf   = head_dat.ovf;
    end
  end

endmodule

// File: tb/tb_add_stream_unit.sv
// Directed bench for add_stream_unit with an independent 4-bit reference model and result scoreboard.
// Expected results are queued at acceptance and compared when the unit pops them.
// Honours ADD_STREAM_SAT_EN so both builds can be checked.
module tb_add_stream_unit;
  import add_stream_pkg::*;

  localparam int W = 4;
  localparam int D = 4;

`ifdef ADD_STREAM_SAT_EN
  localparam logic [3:0] EXP_ADD79  = 4'hF;
  localparam logic [3:0] EXP_SUB35  = 4'h0;
  localparam logic [3:0] EXP_ACC9   = 4'hF;
  localparam logic [3:0] EXP_ACC0   = 4'hF;
`else
  localparam logic [3:0] EXP_ADD79  = 4'h0;
  localparam logic [3:0] EXP_SUB35  = 4'hE;
  localparam logic [3:0] EXP_ACC9   = 4'h2;
  localparam logic [3:0] EXP_ACC0   = 4'h2;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry;
  logic         ovf;
  logic [2:0]   count;

  int           tests = 0;
  int           fails = 0;
  logic [5:0]   scb [$];
  logic [3:0]   m_acc = '0;
  logic [5:0]   mon_e;
  logic [3:0]   mon_na;

  always #5 clk = ~clk;

  add_stream_unit #(.ADD_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .ovf       (ovf),
    .count     (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model using signed/unsigned integer arithmetic; returns {sum, carry, ovf}.
  function automatic logic [5:0] ref_beat(input logic [3:0] ta, input logic [3:0] tb_in,
                                          input logic [1:0] tm, input logic [3:0] tacc,
                                          output logic [3:0] nacc);
    int ua, ub, uc, sa, sb, sc, r, s;
    logic cy, ov;
    logic [3:0] sm;
    ua = int'(ta);
    ub = int'(tb_in);
    uc = int'(tacc);
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    sc = (uc >= 8) ? uc - 16 : uc;
    nacc = tacc;
    cy = 1'b0;
    ov = 1'b0;
    case (tm)
      2'd0: begin r = ua + ub; s = sa + sb; cy = (r > 15); ov = (s > 7) || (s < -8); sm = 4'(r); end
      2'd1: begin r = ua - ub; s = sa - sb; cy = (ua < ub); ov = (s > 7) || (s < -8); sm = 4'(r); end
      2'd2: begin r = uc + ua; s = sc + sa; cy = (r > 15); ov = (s > 7) || (s < -8); sm = 4'(r); end
      default: begin sm = ta; end
    endcase
`ifdef ADD_STREAM_SAT_EN
    if (cy) sm = (tm == 2'd1) ? 4'h0 : 4'hF;
`endif
    if (tm == 2'd2 || tm == 2'd3) nacc = sm;
    return {sm, cy, ov};
  endfunction

  // Scoreboard: pop/compare on a consumed head, push expectation on an accepted beat.
  always @(negedge clk) begin
    if (rst) begin
      scb.delete();
      m_acc = '0;
    end else begin
      if (!out_valid) chk("idle_zero", 32'({sum, carry, ovf}), 32'd0);
      if (out_valid && out_ready) begin
        if (scb.size() == 0) begin
          chk("sb_underflow", 32'(scb.size()), 32'd1);
        end else begin
          mon_e = scb.pop_front();
          chk("sb_result", 32'({sum, carry, ovf}), 32'(mon_e));
        end
      end
      if (in_valid && in_ready) begin
        mon_e = ref_beat(a, b, mode, m_acc, mon_na);
        m_acc = mon_na;
        scb.push_back(mon_e);
      end
    end
  end

  task automatic send(input logic [3:0] ta, input logic [3:0] tb_in, input logic [1:0] tm);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    a        = ta;
    b        = tb_in;
    mode     = tm;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int guard;
    guard = 0;
    while (count != 0 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("drain_count", 32'(count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    mode      = 2'd0;

    // Reset state
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outputs", 32'({sum, carry, ovf}), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // ADD 7 + 9
    send(4'h7, 4'h9, ADD);
    chk("add_out_valid", 32'(out_valid), 32'd1);
    chk("add_sum", 32'(sum), 32'(EXP_ADD79));
    chk("add_carry", 32'(carry), 32'd1);
    chk("add_ovf", 32'(ovf), 32'd0);

    // SUB cases
    send(4'h3, 4'h5, SUB);
    chk("sub35_sum", 32'(sum), 32'(EXP_SUB35));
    chk("sub35_borrow", 32'(carry), 32'd1);
    chk("sub35_ovf", 32'(ovf), 32'd0);
    send(4'h8, 4'h1, SUB);
    chk("sub81_sum", 32'(sum), 32'd7);
    chk("sub81_borrow", 32'(carry), 32'd0);
    chk("sub81_ovf", 32'(ovf), 32'd1);

    // LOAD then accumulate
    send(4'h2, 4'hA, LOAD);
    chk("load_sum", 32'(sum), 32'd2);
    chk("load_flags", 32'({carry, ovf}), 32'd0);
    send(4'h3, 4'h0, ACC);
    chk("acc3_sum", 32'(sum), 32'd5);
    send(4'h4, 4'h0, ACC);
    chk("acc4_sum", 32'(sum), 32'd9);
    send(4'h9, 4'h0, ACC);
    chk("acc9_sum", 32'(sum), 32'(EXP_ACC9));
    chk("acc9_carry", 32'(carry), 32'd1);
    send(4'h0, 4'h5, ACC);
    chk("acc0_sum", 32'(sum), 32'(EXP_ACC0));
    wait_empty();

    // Back-pressure: fill with consumer stalled
    out_ready = 1'b0;
    send(4'h1, 4'h1, ADD);
    send(4'h2, 4'h2, ADD);
    send(4'h3, 4'h3, SUB);
    send(4'h4, 4'h4, ADD);
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    a        = 4'h5;
    b        = 4'h6;
    mode     = ADD;
    repeat (2) @(posedge clk);
    #1;
    chk("stall_count", 32'(count), 32'd4);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("one_pop_count", 32'(count), 32'd3);
    chk("one_pop_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("refill_count", 32'(count), 32'd4);
    out_ready = 1'b1;
    wait_empty();
    chk("no_loss", 32'(scb.size()), 32'd0);

    // Sustained push and pop across pointer wrap
    out_ready = 1'b0;
    send(4'hC, 4'h3, ADD);
    send(4'h1, 4'h7, SUB);
    send(4'h5, 4'h0, LOAD);
    send(4'h6, 4'h0, ACC);
    chk("stream_fill", 32'(count), 32'd4);
    in_valid  = 1'b1;
    a         = 4'h1;
    b         = 4'h2;
    mode      = 2'd0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stream_first_pop", 32'(count), 32'd3);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("stream_count", 32'(count), 32'd3);
      a    = 4'((i + 1) * 3 + 1);
      b    = 4'((i + 1) * 5 + 2);
      mode = 2'((i + 1) % 3);
    end
    in_valid = 1'b0;
    wait_empty();
    chk("stream_no_loss", 32'(scb.size()), 32'd0);

    // Reset mid-stream
    out_ready = 1'b0;
    send(4'h6, 4'h0, LOAD);
    send(4'h1, 4'h2, ADD);
    send(4'h3, 4'h4, ADD);
    chk("pre_rst_count", 32'(count), 32'd3);
    in_valid = 1'b1;
    a        = 4'h5;
    mode     = ACC;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    send(4'h1, 4'h0, ACC);
    chk("post_rst_acc_valid", 32'(out_valid), 32'd1);
    chk("post_rst_acc_sum", 32'(sum), 32'd1);
    wait_empty();
    chk("final_sb_empty", 32'(scb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
